clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Multi-channel, runtime-programmable clock divider with 50% duty cycle for both even and odd ratios. It is the parametrised successor to the fixed-ratio single-output divider. Each channel takes its own divide ratio through a shared configuration port and produces:
- a divided clock, `clk_out`;
- a one-cycle `tick` strobe aligned to each divided period, for logic that stays on `clk`.

Ratio changes take effect only at a period boundary, so no output glitches or runt pulses occur.

## Interface
- `NCH`, 4: number of independent channels (≥1).
- `W`, 8: divisor width; legal divisors are 0 (stop) and 2..2^W−1.
- `DIV_INIT`, 2: active divisor of every channel after reset; must be 0 or 2..2^W−1.
- `CW`: derived channel-index width, max(1, $clog2(NCH)).

Ports:
- `clk` in 1: single clock; the block uses both edges.
- `rst` in 1: synchronous, active-high reset.
- `en` in NCH: per-channel enable; when low, that channel's counter and outputs hold.
- `cfg_we` in 1: configuration write strobe, sampled at posedge `clk`.
- `cfg_ch` in CW: target channel of the write.
- `cfg_div` in W: new divisor for the target channel.
- `cfg_err` out 1: registered one-cycle pulse; the write was rejected.
- `busy` out NCH: channel holds a pending divisor that is not yet applied.
- `tick` out NCH: registered one-cycle pulse in the first source cycle of each divided period.
- `clk_out` out NCH: divided clock, 50% duty.

## Operation
Per-channel state:
- `act` (W): active divisor D.
- `pend` (W) and `pend_v`: pending divisor and its valid flag.
- `cnt` (W): period counter, 0..D−1.
- `pos_q`: posedge register.
- `neg_q`: negedge register.

Reset (rst=1 at posedge):
- `act`=DIV_INIT, `cnt`=0, `pend_v`=0.
- `pos_q`, `neg_q`, `tick`, `cfg_err`, `busy` and `clk_out` all 0.
- `neg_q` clears at the first negedge after a posedge with rst=1.
- Reset mid-period aborts the period; no partial pulse completes.
- `cfg_we` is ignored while rst=1.

Configuration:
- A write with `cfg_ch` < NCH and `cfg_div` ≠ 1 sets `pend`=`cfg_div` and `pend_v`=1.
- A second write before the first is applied overwrites `pend` (last write wins).
- A write with `cfg_ch` ≥ NCH or `cfg_div` == 1 is ignored, and `cfg_err` pulses in the next cycle.
- Writes to one channel never disturb the others.

Running channel, D ≥ 2, `en`=1, each posedge:
- `cnt` ← (`cnt`==D−1) ? 0 : `cnt`+1.
- `pos_q` is high for exactly the cycles in which `cnt` < floor(D/2).
- `tick` is high in the cycle in which `cnt`==0.

Even D: `clk_out` = `pos_q`.

Odd D:
- `neg_q` samples `pos_q` on negedge.
- `clk_out` = `pos_q` | `neg_q`.
- High time is (D−1)/2 + ½ source cycles.

Boundary (applying a pending divisor):
- Occurs at the posedge where `cnt`==D−1, `en`=1 and `pend_v`=1.
- Effects: `act` ← `pend`, `cnt` ← 0, `pend_v` ← 0.
- The next period uses the new D.
- A write landing in the same cycle as a boundary is captured into `pend` and waits for the following boundary.

Stopped channel (D = 0):
- `cnt` holds 0; `pos_q`, `neg_q`, `clk_out` and `tick` are 0.
- Every enabled cycle counts as a boundary, so a pending divisor applies at the first posedge with `en`=1 and `pend_v`=1.
- Writing 0 to a running channel stops it at its next boundary; the current period completes first.

`en` low:
- `cnt`, `pos_q` and `neg_q` hold their values.
- `tick` is forced 0.
- Pending divisors do not apply.
- On re-enable, the channel resumes from the held count.

## Timing
- Write at posedge t: `busy` is high from t+1; `cfg_err` (if rejected) is high for cycle t+1 only.
- Apply at boundary posedge b: `busy` is low from b+1; the new period starts with `cnt`=0 in cycle b+1.
- `tick` in that cycle carries no extra latency.
- Output alignment: `clk_out` rises 1 cycle after the posedge that registers `cnt`=0, coincident with `tick`.
- Even D: `clk_out` falls after D/2 cycles.
- Odd D: `clk_out` falls on the negedge (D−1)/2 + ½ cycles after rising.
- Period is exactly D source cycles, with no gap or overlap across a divisor change.
- Reset, `tick`, `cfg_err`, `busy` and `pos_q` are registered on posedge; `neg_q` is the only negedge flop.

## Test plan
- Reset with DIV_INIT=2, `en`=all 1 → all `clk_out` toggle every cycle; `tick` is high every 2nd cycle; `busy`=0.
- Channel 1 programmed to 3 (from running at 2) → after the boundary, `clk_out` period is 3 cycles and high for 1.5 cycles; `tick` every 3rd cycle; `busy` low one cycle after apply.
- Write 8 to channel 0, then 5 before the boundary → only 5 is applied; period 5 with 2.5-cycle high time; no 8-cycle period appears.
- Write 0 to channel 2 mid-period → the current period completes, then `clk_out`=0 and `tick`=0. Later write 4 → the channel restarts with `cnt`=0 at the first enabled cycle after the write.
- Write `cfg_div`=1, then `cfg_ch`=NCH (when NCH is not a power of 2) → `cfg_err` pulses for one cycle each; no `busy` change; outputs undisturbed.
- Drop `en[3]` for 4 cycles mid-period, then assert rst mid-period on another channel → channel 3 holds its level and resumes its remaining count; the reset channel shows `clk_out`=0 and `cnt`=0 next cycle and restarts at DIV_INIT.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Configuration write port of clk_div_prog: write strobe, channel select, divisor,
// and the registered reject pulse returned by the divider.
interface clk_div_prog_if #(
    parameter int NCH = 4,
    parameter int W   = 8,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
);
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_err;

    modport master (output cfg_we, output cfg_ch, output cfg_div, input  cfg_err);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div, output cfg_err);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider with 50% duty for even and odd ratios.
// New ratios are held pending and only applied on a period boundary, so clk_out never glitches.
module clk_div_prog #(
    parameter int NCH      = 4,
    parameter int W        = 8,
    parameter int DIV_INIT = 2,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    clk_div_prog_if.slave  cfg,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_out
);

    logic [NCH-1:0][W-1:0] act_q, act_d;
    logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][W-1:0] pend_q, pend_d;
    logic [NCH-1:0]        pend_v_q, pend_v_d;
    logic [NCH-1:0]        pos_q, pos_d;
    logic [NCH-1:0]        odd_q, odd_d;
    logic [NCH-1:0]        tick_q, tick_d;
    logic [NCH-1:0]        neg_q, neg_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  cfg_bad;
    logic [NCH-1:0]        wrap;
    logic [NCH-1:0]        bnd;

    always_comb begin
        act_d     = act_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        pos_d     = pos_q;
        odd_d     = odd_q;
        tick_d    = '0;
        wrap      = '0;
        bnd       = '0;
        cfg_bad   = (32'(cfg.cfg_ch) >= NCH) || (cfg.cfg_div == W'(1));
        cfg_err_d = cfg.cfg_we && cfg_bad;
        for (int i = 0; i < NCH; i++) begin
            // A stopped channel (act 0) sits on a boundary every enabled cycle.
            wrap[i] = (act_q[i] == '0) || (cnt_q[i] == act_q[i] - W'(1));
            bnd[i]  = en[i] && pend_v_q[i] && wrap[i];
            if (en[i]) begin
                cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + W'(1);
                pos_d[i]  = (act_q[i] != '0) && (cnt_q[i] < (act_q[i] >> 1));
                odd_d[i]  = act_q[i][0];
                tick_d[i] = (act_q[i] != '0) && (cnt_q[i] == '0);
            end
            if (bnd[i]) begin
                act_d[i]    = pend_q[i];
                pend_v_d[i] = 1'b0;
            end
            // A write coinciding with a boundary stays pending for the next one.
            if (cfg.cfg_we && !cfg_bad && (cfg.cfg_ch == CW'(i))) begin
                pend_d[i]   = cfg.cfg_div;
                pend_v_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q     <= {NCH{W'(DIV_INIT)}};
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= '0;
            pos_q     <= '0;
            odd_q     <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            act_q     <= act_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            pos_q     <= pos_d;
            odd_q     <= odd_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Half-cycle delayed copy of pos_q; it stretches the high phase for odd ratios.
    always_comb neg_d = pos_q;

    always_ff @(negedge clk) begin
        neg_q <= neg_d;
    end

    // odd_q travels with pos_q so a ratio change cannot mix parity across the boundary.
    assign clk_out     = pos_q | (odd_q & neg_q);
    assign busy        = pend_v_q;
    assign tick        = tick_q;
    assign cfg.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: scenario tasks plus a per-channel period scoreboard
// fed with the divisors each configuration write is expected to apply.
module tb_clk_div_prog;
    localparam int NCH      = 5;
    localparam int W        = 8;
    localparam int CW       = 3;
    localparam int DIV_INIT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en  = '0;
    logic [NCH-1:0] busy, tick, clk_out;

    int n_asserts = 0;
    int n_fail    = 0;
    bit mon_on    = 1'b0;

    // Expected divisors awaiting application, per channel.
    int exp_q [NCH][$];
    int cur_d [NCH];
    int start_d [NCH];
    int per_h [NCH];
    int high_h [NCH];
    int nlow [NCH];
    bit have_rise [NCH];
    bit prev_clk [NCH];
    bit prev_busy [NCH];

    clk_div_prog_if #(.NCH(NCH), .W(W)) cfg_if ();

    clk_div_prog #(.NCH(NCH), .W(W), .DIV_INIT(DIV_INIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg_if),
        .busy    (busy),
        .tick    (tick),
        .clk_out (clk_out)
    );

    initial forever #5 clk = ~clk;

    // Monitor: samples 1 ns after every edge; periods and high times are counted in half cycles.
    always @(posedge clk or negedge clk) begin : mon
        bit at_pos;
        bit cv;
        bit rise;
        bit fall;
        at_pos = clk;
        #1;
        if (mon_on) begin
            for (int c = 0; c < NCH; c++) begin
                cv = clk_out[c];
                if (at_pos && rst) begin
                    have_rise[c] = 1'b0;
                    cur_d[c]     = DIV_INIT;
                    start_d[c]   = DIV_INIT;
                    exp_q[c].delete();
                    nlow[c]      = 0;
                    per_h[c]     = 0;
                    high_h[c]    = 0;
                    prev_clk[c]  = cv;
                    prev_busy[c] = 1'b0;
                end else begin
                    if (at_pos && !en[c]) nlow[c]++;
                    per_h[c]++;
                    rise = cv && !prev_clk[c];
                    fall = !cv && prev_clk[c];
                    if (cv && !rise) high_h[c]++;
                    if (rise) begin
                        n_asserts++;
                        if (cur_d[c] == 0) begin
                            n_fail++;
                            $display("FAIL sb_rise_while_stopped ch%0d: clk_out rose, expected channel stopped", c);
                        end
                        if (have_rise[c]) begin
                            n_asserts++;
                            if (per_h[c] != 2 * (start_d[c] + nlow[c])) begin
                                n_fail++;
                                $display("FAIL sb_period ch%0d: got %0d half-cycles, expected %0d", c, per_h[c], 2 * (start_d[c] + nlow[c]));
                            end
                        end
                        have_rise[c] = 1'b1;
                        start_d[c]   = cur_d[c];
                        per_h[c]     = 0;
                        high_h[c]    = 1;
                        nlow[c]      = 0;
                    end
                    if (fall && have_rise[c] && nlow[c] == 0) begin
                        n_asserts++;
                        if (high_h[c] != start_d[c]) begin
                            n_fail++;
                            $display("FAIL sb_high_time ch%0d: got %0d half-cycles, expected %0d", c, high_h[c], start_d[c]);
                        end
                    end
                    if (at_pos) begin
                        n_asserts++;
                        if (tick[c] !== rise) begin
                            n_fail++;
                            $display("FAIL sb_tick_align ch%0d: tick=%0b, expected %0b", c, tick[c], rise);
                        end
                        if (prev_busy[c] && !busy[c]) begin
                            n_asserts++;
                            if (exp_q[c].size() == 0) begin
                                n_fail++;
                                $display("FAIL sb_unexpected_apply ch%0d: busy fell, expected no pending divisor", c);
                            end else begin
                                cur_d[c] = exp_q[c].pop_front();
                                if (cur_d[c] == 0) have_rise[c] = 1'b0;
                            end
                        end
                        prev_busy[c] = busy[c];
                    end
                    prev_clk[c] = cv;
                end
            end
        end
    end

    task automatic write_cfg(input int ch, input int d);
        @(posedge clk); #2;
        cfg_if.cfg_we  = 1'b1;
        cfg_if.cfg_ch  = CW'(ch);
        cfg_if.cfg_div = W'(d);
        if (exp_q[ch].size() != 0) void'(exp_q[ch].pop_back());
        exp_q[ch].push_back(d);
        @(posedge clk); #1;
        n_asserts++;
        if (busy[ch] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy ch%0d: busy=%0b, expected 1", ch, busy[ch]);
        end
        n_asserts++;
        if (cfg_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_err ch%0d: cfg_err=%0b, expected 0", ch, cfg_if.cfg_err);
        end
        #1 cfg_if.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] exp_v;
        cfg_if.cfg_we  = 1'b0;
        cfg_if.cfg_ch  = '0;
        cfg_if.cfg_div = '0;
        en  = '1;
        rst = 1'b1;
        @(posedge clk);
        mon_on = 1'b1;
        #1;
        n_asserts++;
        if (clk_out !== '0 || tick !== '0 || busy !== '0 || cfg_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: clk_out=%b tick=%b busy=%b cfg_err=%b, expected all 0", clk_out, tick, busy, cfg_if.cfg_err);
        end
        #1;
        // A write during reset must be ignored.
        cfg_if.cfg_we  = 1'b1;
        cfg_if.cfg_div = W'(9);
        @(posedge clk); #2;
        cfg_if.cfg_we = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_v = (k % 2 == 1) ? '1 : '0;
            n_asserts++;
            if (clk_out !== exp_v || tick !== exp_v || busy !== '0) begin
                n_fail++;
                $display("FAIL reset_div2 cyc%0d: clk_out=%b tick=%b busy=%b, expected %b %b 0", k, clk_out, tick, busy, exp_v, exp_v);
            end
        end
    endtask

    task automatic test_reprogram_odd();
        int k;
        int nt;
        write_cfg(1, 3);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (busy[1] !== 1'b0 && k < 20);
        n_asserts++;
        if (busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_apply: busy[1]=%0b after %0d cycles, expected 0", busy[1], k);
        end
        nt = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (tick[1]) nt++;
        end
        n_asserts++;
        if (nt != 4) begin
            n_fail++;
            $display("FAIL odd_tick_count: got %0d ticks in 12 cycles, expected 4", nt);
        end
    endtask

    task automatic test_last_write_wins();
        int k;
        @(posedge clk); #2;
        en[0] = 1'b0;
        write_cfg(0, 8);
        write_cfg(0, 5);
        #1 en[0] = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (busy[0] !== 1'b0 && k < 20);
        n_asserts++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lww_apply: busy[0]=%0b, expected 0", busy[0]);
        end
        k = 0;
        while (tick[0] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        k = 0;
        do begin @(posedge clk); #1; k++; end while (tick[0] !== 1'b1 && k < 20);
        n_asserts++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL lww_tick_interval: got %0d cycles, expected 5", k);
        end
        repeat (12) @(posedge clk);
    endtask

    task automatic test_stop_restart();
        int k;
        write_cfg(2, 0);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (busy[2] !== 1'b0 && k < 20);
        n_asserts++;
        if (busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_apply: busy[2]=%0b, expected 0", busy[2]);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); #1;
            n_asserts++;
            if (clk_out[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_clk_neg cyc%0d: clk_out[2]=%0b, expected 0", j, clk_out[2]);
            end
            @(posedge clk); #1;
            n_asserts++;
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_quiet cyc%0d: clk_out[2]=%0b tick[2]=%0b, expected 0 0", j, clk_out[2], tick[2]);
            end
        end
        write_cfg(2, 4);
        @(posedge clk); #1;
        n_asserts++;
        if (busy[2] !== 1'b0 || tick[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_apply: busy[2]=%0b tick[2]=%0b, expected 0 0", busy[2], tick[2]);
        end
        @(posedge clk); #1;
        n_asserts++;
        if (tick[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_first_tick: tick[2]=%0b clk_out[2]=%0b, expected 1 1", tick[2], clk_out[2]);
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_cfg_err();
        int chs [3];
        int dvs [3];
        chs = '{1, NCH, 7};
        dvs = '{1, 6, 6};
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #2;
            cfg_if.cfg_we  = 1'b1;
            cfg_if.cfg_ch  = CW'(chs[j]);
            cfg_if.cfg_div = W'(dvs[j]);
            @(posedge clk); #1;
            n_asserts++;
            if (cfg_if.cfg_err !== 1'b1 || busy !== '0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse ch%0d div%0d: cfg_err=%0b busy=%b, expected 1 0", chs[j], dvs[j], cfg_if.cfg_err, busy);
            end
            #1 cfg_if.cfg_we = 1'b0;
            @(posedge clk); #1;
            n_asserts++;
            if (cfg_if.cfg_err !== 1'b0 || busy !== '0) begin
                n_fail++;
                $display("FAIL cfg_err_one_cycle ch%0d: cfg_err=%0b busy=%b, expected 0 0", chs[j], cfg_if.cfg_err, busy);
            end
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_en_hold_and_reset();
        int k;
        write_cfg(3, 6);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (busy[3] !== 1'b0 && k < 20);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (tick[3] !== 1'b1 && k < 20);
        n_asserts++;
        if (tick[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_find_tick: tick[3]=%0b, expected 1", tick[3]);
        end
        #1 en[3] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            n_asserts++;
            if (clk_out[3] !== 1'b1 || tick[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_level cyc%0d: clk_out[3]=%0b tick[3]=%0b, expected 1 0", j, clk_out[3], tick[3]);
            end
        end
        #1 en[3] = 1'b1;
        k = 4;
        do begin @(posedge clk); #1; k++; end while (tick[3] !== 1'b1 && k < 30);
        n_asserts++;
        if (k != 10) begin
            n_fail++;
            $display("FAIL hold_resume: next tick after %0d cycles, expected 10", k);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_asserts++;
        if (clk_out !== '0 || tick !== '0 || busy !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: clk_out=%b tick=%b busy=%b, expected all 0", clk_out, tick, busy);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_asserts++;
        if (clk_out !== '1 || tick !== '1) begin
            n_fail++;
            $display("FAIL midreset_restart: clk_out=%b tick=%b, expected all 1", clk_out, tick);
        end
        @(posedge clk); #1;
        n_asserts++;
        if (clk_out !== '0 || tick !== '0) begin
            n_fail++;
            $display("FAIL midreset_div2: clk_out=%b tick=%b, expected all 0", clk_out, tick);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_drain();
        for (int c = 0; c < NCH; c++) begin
            n_asserts++;
            if (exp_q[c].size() != 0) begin
                n_fail++;
                $display("FAIL sb_leftover ch%0d: %0d divisors never applied, expected 0", c, exp_q[c].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reprogram_odd();
        test_last_write_wins();
        test_stop_restart();
        test_cfg_err();
        test_en_hold_and_reset();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
